// File: rtl/cu_pkg.sv
// Shared decode constants and the packed control bundle for the control-unit pipe stage.
package cu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] DW_W  = 3'b000;
  localparam logic [2:0] DW_H  = 3'b001;
  localparam logic [2:0] DW_B  = 3'b010;
  localparam logic [2:0] DW_HU = 3'b101;
  localparam logic [2:0] DW_BU = 3'b110;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_GE  = 4'b0010;
  localparam logic [3:0] ALU_LT  = 4'b0011;
  localparam logic [3:0] ALU_EQ  = 4'b1000;
  localparam logic [3:0] ALU_LUI = 4'b1001;

  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_t;

  typedef struct packed {
    logic       jalr;
    logic       jal;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       alu_src;
    logic       cache_en;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic [3:0] alu_ctrl;
    logic [2:0] data_width;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       illegal;
  } ctrl_t;

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OP_R) || (op == OP_LOAD) || (op == OP_IMM) ||
           (op == OP_JALR) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Purely combinational instruction decode into the control bundle.
module cu_decode
  import cu_pkg::*;
#(
  parameter bit ENABLE_AUIPC = 1'b1
) (
  input  logic [31:0] instr,
  input  logic        dummy_unused,
  output ctrl_t       ctrl
);
  logic [6:0] op;
  logic [2:0] f3;
  logic       f7b5;
  logic       unused_bits;

  assign op          = instr[6:0];
  assign f3          = instr[14:12];
  assign f7b5        = instr[30];
  assign unused_bits = ^{instr[31], instr[29:25], dummy_unused};

  always_comb begin
    ctrl        = '0;
    ctrl.funct3 = f3;
    ctrl.rd     = instr[11:7];
    ctrl.rs1    = instr[19:15];
    ctrl.rs2    = instr[24:20];
    case (op)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_ctrl  = {f7b5, f3};
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.cache_en   = 1'b1;
        ctrl.result_src = 2'b01;
        case (f3)
          3'b000:  ctrl.data_width = DW_B;
          3'b001:  ctrl.data_width = DW_H;
          3'b100:  ctrl.data_width = DW_BU;
          3'b101:  ctrl.data_width = DW_HU;
          default: ctrl.data_width = DW_W;
        endcase
      end
      OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        // only the shift-right group uses f7[5] to pick arithmetic vs logical
        ctrl.alu_ctrl  = (f3 == 3'b101) ? {f7b5, f3} : {1'b0, f3};
      end
      OP_JALR: begin
        ctrl.branch     = 1'b1;
        ctrl.jalr       = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = 2'b10;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.cache_en  = 1'b1;
        ctrl.imm_src   = 3'b001;
        case (f3)
          3'b000:  ctrl.data_width = DW_B;
          3'b001:  ctrl.data_width = DW_H;
          default: ctrl.data_width = DW_W;
        endcase
      end
      OP_BRANCH: begin
        ctrl.branch  = 1'b1;
        ctrl.imm_src = 3'b010;
        case (f3)
          3'b000, 3'b001: ctrl.alu_ctrl = ALU_EQ;
          3'b100:         ctrl.alu_ctrl = ALU_LT;
          3'b101:         ctrl.alu_ctrl = ALU_GE;
          3'b110, 3'b111: ctrl.alu_ctrl = ALU_LT;
          default:        ctrl.alu_ctrl = ALU_ADD;
        endcase
      end
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.imm_src   = 3'b100;
        ctrl.alu_ctrl  = ALU_LUI;
      end
      OP_JAL: begin
        ctrl.branch     = 1'b1;
        ctrl.jal        = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.result_src = 2'b10;
        ctrl.imm_src    = 3'b011;
      end
      OP_AUIPC: begin
        if (ENABLE_AUIPC) begin
          ctrl.reg_write  = 1'b1;
          ctrl.alu_src    = 1'b1;
          ctrl.imm_src    = 3'b100;
          ctrl.result_src = 2'b11;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/cu_pipe.sv
// Decode pipe stage: registered control bundle with valid/ready, load-use bubble,
// branch flush and a saturating illegal-instruction counter.
module cu_pipe
  import cu_pkg::*;
#(
  parameter bit ENABLE_AUIPC = 1'b1,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr_i,
  input  logic             instr_valid_i,
  output logic             instr_ready_o,
  input  logic             flush_i,
  input  logic             ctrl_ready_i,
  output logic             ctrl_valid_o,
  output logic             JALR,
  output logic             JAL,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             Branch,
  output logic             ALUsrc,
  output logic             CacheEn,
  output logic [1:0]       ResultSrc,
  output logic [2:0]       ImmSrc,
  output logic [3:0]       ALUctrl,
  output logic [2:0]       DataWidth,
  output logic [2:0]       funct3,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt_o
);
  ctrl_t            dec, ctrl_q;
  logic             vld_q;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             q_is_load, reads_rd, hazard, accept;
  logic [6:0]       op;

  cu_decode #(.ENABLE_AUIPC(ENABLE_AUIPC)) u_dec (
    .instr        (instr_i),
    .dummy_unused (1'b0),
    .ctrl         (dec)
  );

  assign op        = instr_i[6:0];
  assign q_is_load = ctrl_q.cache_en && !ctrl_q.mem_write && (ctrl_q.rd != 5'd0);
  assign reads_rd  = (uses_rs1(op) && (instr_i[19:15] == ctrl_q.rd)) ||
                     (uses_rs2(op) && (instr_i[24:20] == ctrl_q.rd));
  // a flushed instruction is about to be dropped, so it cannot create a hazard
  assign hazard    = vld_q && q_is_load && instr_valid_i && !flush_i && reads_rd;

  assign instr_ready_o = (state == RUN) && !hazard && (!vld_q || ctrl_ready_i);
  assign accept        = instr_valid_i && instr_ready_o && !flush_i;

  // the bubble is entered only once the load has actually left downstream
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (hazard && ctrl_ready_i) state_nxt = BUBBLE;
      BUBBLE:  state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    if (flush_i) state_nxt = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      vld_q  <= 1'b0;
      ctrl_q <= '0;
      cnt_q  <= '0;
    end else begin
      state <= state_nxt;
      if (flush_i)           vld_q <= 1'b0;
      else if (accept)       vld_q <= 1'b1;
      else if (ctrl_ready_i) vld_q <= 1'b0;
      if (accept) ctrl_q <= dec;
      if (accept && dec.illegal && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign ctrl_valid_o  = vld_q;
  assign illegal_cnt_o = cnt_q;
  assign JALR          = ctrl_q.jalr;
  assign JAL           = ctrl_q.jal;
  assign MemWrite      = ctrl_q.mem_write;
  assign RegWrite      = ctrl_q.reg_write;
  assign Branch        = ctrl_q.branch;
  assign ALUsrc        = ctrl_q.alu_src;
  assign CacheEn       = ctrl_q.cache_en;
  assign ResultSrc     = ctrl_q.result_src;
  assign ImmSrc        = ctrl_q.imm_src;
  assign ALUctrl       = ctrl_q.alu_ctrl;
  assign DataWidth     = ctrl_q.data_width;
  assign funct3        = ctrl_q.funct3;
  assign rd            = ctrl_q.rd;
  assign rs1           = ctrl_q.rs1;
  assign rs2           = ctrl_q.rs2;
  assign illegal       = ctrl_q.illegal;
endmodule

// File: tb/tb_cu_pipe.sv
// Directed plus randomized checks of cu_pipe against a transaction-level model.
module tb_cu_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        ivalid = 1'b0, flush = 1'b0, cready = 1'b1;
  int          vectors = 0, miscompares = 0;

  logic        iready, cvalid, jalr, jal, mw, rw, br, as, ce, ill;
  logic [1:0]  rsrc;
  logic [2:0]  isrc, dw, f3;
  logic [3:0]  ac;
  logic [4:0]  rd, rs1, rs2;
  logic [1:0]  cnt;

  logic        n_iready, n_cvalid, n_jalr, n_jal, n_mw, n_rw, n_br, n_as, n_ce, n_ill;
  logic [1:0]  n_rsrc;
  logic [2:0]  n_isrc, n_dw, n_f3;
  logic [3:0]  n_ac;
  logic [4:0]  n_rd, n_rs1, n_rs2;
  logic [7:0]  n_cnt;

  wire [37:0] obs   = {jalr, jal, mw, rw, br, as, ce, rsrc, isrc, ac, dw, f3, rd, rs1, rs2, ill};
  wire [37:0] n_obs = {n_jalr, n_jal, n_mw, n_rw, n_br, n_as, n_ce, n_rsrc, n_isrc, n_ac, n_dw,
                       n_f3, n_rd, n_rs1, n_rs2, n_ill};

  cu_pipe #(.ENABLE_AUIPC(1'b1), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .instr_i(instr), .instr_valid_i(ivalid), .instr_ready_o(iready),
    .flush_i(flush), .ctrl_ready_i(cready), .ctrl_valid_o(cvalid), .JALR(jalr), .JAL(jal),
    .MemWrite(mw), .RegWrite(rw), .Branch(br), .ALUsrc(as), .CacheEn(ce), .ResultSrc(rsrc),
    .ImmSrc(isrc), .ALUctrl(ac), .DataWidth(dw), .funct3(f3), .rd(rd), .rs1(rs1), .rs2(rs2),
    .illegal(ill), .illegal_cnt_o(cnt));

  cu_pipe #(.ENABLE_AUIPC(1'b0), .CNT_W(8)) dut_na (
    .clk(clk), .rst_n(rst_n), .instr_i(instr), .instr_valid_i(ivalid), .instr_ready_o(n_iready),
    .flush_i(flush), .ctrl_ready_i(cready), .ctrl_valid_o(n_cvalid), .JALR(n_jalr), .JAL(n_jal),
    .MemWrite(n_mw), .RegWrite(n_rw), .Branch(n_br), .ALUsrc(n_as), .CacheEn(n_ce),
    .ResultSrc(n_rsrc), .ImmSrc(n_isrc), .ALUctrl(n_ac), .DataWidth(n_dw), .funct3(n_f3),
    .rd(n_rd), .rs1(n_rs1), .rs2(n_rs2), .illegal(n_ill), .illegal_cnt_o(n_cnt));

  always #5 clk = ~clk;

  // Expected bundle straight from the opcode table, in output-port order.
  function automatic logic [37:0] exp_bundle(input logic [31:0] in, input bit auipc_en);
    logic e_jalr, e_jal, e_mw, e_rw, e_br, e_as, e_ce, e_ill;
    logic [1:0] e_rs;
    logic [2:0] e_is, e_dw, e_f3;
    logic [3:0] e_ac;
    {e_jalr, e_jal, e_mw, e_rw, e_br, e_as, e_ce, e_ill} = '0;
    e_rs = 2'b00; e_is = 3'b000; e_dw = 3'b000; e_ac = 4'b0000;
    e_f3 = in[14:12];
    case (in[6:0])
      7'b0110011: begin e_rw = 1; e_ac = {in[30], e_f3}; end
      7'b0000011: begin
        e_rw = 1; e_as = 1; e_ce = 1; e_rs = 2'b01;
        case (e_f3) 0: e_dw = 3'b010; 1: e_dw = 3'b001; 4: e_dw = 3'b110; 5: e_dw = 3'b101;
          default: e_dw = 3'b000; endcase
      end
      7'b0010011: begin e_rw = 1; e_as = 1; e_ac = (e_f3 == 5) ? {in[30], e_f3} : {1'b0, e_f3}; end
      7'b1100111: begin e_br = 1; e_jalr = 1; e_rw = 1; e_as = 1; e_rs = 2'b10; end
      7'b0100011: begin
        e_mw = 1; e_as = 1; e_ce = 1; e_is = 3'b001;
        case (e_f3) 0: e_dw = 3'b010; 1: e_dw = 3'b001; default: e_dw = 3'b000; endcase
      end
      7'b1100011: begin
        e_br = 1; e_is = 3'b010;
        case (e_f3) 0, 1: e_ac = 4'b1000; 4, 6, 7: e_ac = 4'b0011; 5: e_ac = 4'b0010;
          default: e_ac = 4'b0000; endcase
      end
      7'b0110111: begin e_rw = 1; e_as = 1; e_is = 3'b100; e_ac = 4'b1001; end
      7'b1101111: begin e_br = 1; e_jal = 1; e_rw = 1; e_as = 1; e_rs = 2'b10; e_is = 3'b011; end
      7'b0010111: begin
        if (auipc_en) begin e_rw = 1; e_as = 1; e_is = 3'b100; e_rs = 2'b11; end
        else e_ill = 1;
      end
      default: e_ill = 1;
    endcase
    return {e_jalr, e_jal, e_mw, e_rw, e_br, e_as, e_ce, e_rs, e_is, e_ac, e_dw, e_f3,
            in[11:7], in[19:15], in[24:20], e_ill};
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [6:0] ops [10];
    logic [31:0] w;
    ops = '{7'b0110011, 7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b1101111, 7'b0010111, 7'b1111111};
    w = $urandom;
    w[6:0]   = ops[$urandom_range(9, 0)];
    w[11:7]  = 5'($urandom_range(3, 0));
    w[19:15] = 5'($urandom_range(3, 0));
    w[24:20] = 5'($urandom_range(3, 0));
    return w;
  endfunction

  localparam logic [31:0] ADDI1 = 32'h00A00093, ADDI2 = 32'h00500113;
  localparam logic [31:0] LW    = 32'h00012283, ADD   = 32'h00128333;
  localparam logic [31:0] BAD   = 32'hFFFFFFFF, AUIPC = 32'h00000097;

  logic [37:0] q [$];
  logic [31:0] pend;
  bit          pend_v, acc, hs;
  int          cnt_m, ncnt_m;

  initial begin
    // reset state
    #12;
    chk("rst_valid", cvalid, 0);
    chk("rst_bundle", obs, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_ready", iready, 1);
    rst_n = 1'b1;
    tick();

    // addi x1,x0,10
    ivalid = 1; instr = ADDI1; #3;
    chk("addi_ready", iready, 1);
    tick(); ivalid = 0; #3;
    chk("addi_valid", cvalid, 1);
    chk("addi_bundle", obs, exp_bundle(ADDI1, 1));
    chk("addi_fields", {rw, as, ac, rd}, {1'b1, 1'b1, 4'b0000, 5'd1});
    tick();

    // lw x5 then dependent add x6,x5,x1: one bubble
    ivalid = 1; instr = LW; #3;
    chk("lw_ready", iready, 1);
    tick(); instr = ADD; #3;
    chk("lw_valid", cvalid, 1);
    chk("lw_bundle", obs, exp_bundle(LW, 1));
    chk("lw_rsrc", rsrc, 2'b01);
    chk("hazard_ready", iready, 0);
    tick(); #3;
    chk("bubble_valid", cvalid, 0);
    chk("bubble_ready", iready, 0);
    tick(); #3;
    chk("post_bubble_valid", cvalid, 0);
    chk("post_bubble_ready", iready, 1);
    tick(); ivalid = 0; #3;
    chk("add_valid", cvalid, 1);
    chk("add_bundle", obs, exp_bundle(ADD, 1));
    chk("add_rsrc", rsrc, 2'b00);
    tick();

    // lw then add under flush: no bubble, add dropped
    ivalid = 1; instr = LW;
    tick(); instr = ADD; flush = 1; #3;
    chk("flush_ready", iready, 1);
    tick(); ivalid = 0; flush = 0; #3;
    chk("flush_valid", cvalid, 0);
    chk("flush_run", iready, 1);
    tick(); #3;
    chk("flush_dropped", cvalid, 0);

    // hold for 3 cycles with downstream stalled
    ivalid = 1; instr = ADDI1;
    tick(); cready = 0; instr = ADDI2;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("hold_valid", cvalid, 1);
      chk("hold_bundle", obs, exp_bundle(ADDI1, 1));
      chk("hold_ready", iready, 0);
      tick();
    end
    cready = 1; #3;
    chk("resume_ready", iready, 1);
    tick(); ivalid = 0; #3;
    chk("resume_bundle", {cvalid, obs}, {1'b1, exp_bundle(ADDI2, 1)});
    tick();

    // five illegal instructions: 2-bit counter saturates at 3
    chk("cnt_before", cnt, 0);
    ivalid = 1; instr = BAD;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 5) ivalid = 0;
      #3;
      chk("bad_bundle", obs, exp_bundle(BAD, 1));
      chk("bad_cnt", cnt, (k > 3) ? 3 : k);
      chk("bad_cnt_wide", n_cnt, k);
    end
    tick();

    // auipc legal vs disabled
    ivalid = 1; instr = AUIPC;
    tick(); ivalid = 0; #3;
    chk("auipc_bundle", obs, exp_bundle(AUIPC, 1));
    chk("auipc_fields", {rsrc, isrc, rd, ill}, {2'b11, 3'b100, 5'd1, 1'b0});
    chk("auipc_off_bundle", n_obs, exp_bundle(AUIPC, 0));
    chk("auipc_off_ill", {n_ill, n_rw}, 2'b10);
    chk("auipc_off_cnt", n_cnt, 6);
    chk("auipc_cnt", cnt, 3);
    tick();

    // reset while holding
    cready = 0; ivalid = 1; instr = ADDI1;
    tick(); ivalid = 0; #3;
    chk("prerst_valid", cvalid, 1);
    #1 rst_n = 0; #1;
    chk("midrst_valid", cvalid, 0);
    chk("midrst_bundle", obs, 0);
    chk("midrst_cnt", cnt, 0);
    rst_n = 1; cready = 1;
    tick(); #3;
    chk("postrst_valid", cvalid, 0);
    tick();

    // randomized traffic against an in-order scoreboard
    cnt_m = 0; ncnt_m = 0; pend_v = 0;
    for (int c = 0; c < 600; c++) begin
      if (!pend_v && $urandom_range(3, 0) != 0) begin pend = rnd_instr(); pend_v = 1; end
      instr  = pend;
      ivalid = pend_v && ($urandom_range(7, 0) != 0);
      cready = $urandom_range(9, 0) < 7;
      flush  = $urandom_range(24, 0) == 0;
      #3;
      chk("rnd_valid", cvalid, q.size() != 0);
      chk("rnd_valid_na", n_cvalid, q.size() != 0);
      if (q.size() != 0) chk("rnd_bundle", obs, q[0]);
      chk("rnd_cnt", cnt, cnt_m);
      chk("rnd_cnt_na", n_cnt, ncnt_m);
      acc = ivalid && iready && !flush;
      hs  = cvalid && cready;
      if (flush) begin
        q.delete();
        if (ivalid) pend_v = 0;
      end else begin
        if (hs && q.size() != 0) void'(q.pop_front());
        if (acc) begin
          q.push_back(exp_bundle(pend, 1));
          if (exp_bundle(pend, 1) & 38'd1) cnt_m = (cnt_m == 3) ? 3 : cnt_m + 1;
          if (exp_bundle(pend, 0) & 38'd1) ncnt_m = (ncnt_m == 255) ? 255 : ncnt_m + 1;
          pend_v = 0;
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cu_pipe.md
CU_PIPE -- requirements
Module: cu_pipe

Interface
REQ-001 SHALL have parameter ENABLE_AUIPC, default 1, meaning decode opcode 0010111 (auipc) as legal.
REQ-002 SHALL have parameter CNT_W, default 8, meaning width of the saturating illegal-instruction counter.
REQ-003 SHALL have port clk input 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n input 1, reset, asynchronous, active-low.
REQ-005 SHALL have port instr_i input 32, the fetched instruction.
REQ-006 SHALL have port instr_valid_i input 1, meaning instr_i is valid.
REQ-007 SHALL have port instr_ready_o output 1, meaning the block accepts instr_i this cycle.
REQ-008 SHALL have port flush_i input 1, meaning a taken branch/jump kills the in-flight and presented instruction.
REQ-009 SHALL have port ctrl_ready_i input 1, meaning the downstream stage (cache/ALU) accepts the control bundle.
REQ-010 SHALL have port ctrl_valid_o output 1, meaning the registered control bundle is valid.
REQ-011 SHALL have the registered bundle as outputs: JALR 1, JAL 1, MemWrite 1, RegWrite 1, Branch 1, ALUsrc 1, CacheEn 1, ResultSrc 2, ImmSrc 3, ALUctrl 4, DataWidth 3, funct3 3, rd 5, rs1 5, rs2 5, illegal 1.
REQ-012 SHALL have port illegal_cnt_o output CNT_W, the count of accepted illegal instructions.

Function
REQ-013 SHALL register the decoded bundle when instr_valid_i && instr_ready_o; the bundle appears with ctrl_valid_o 1 cycle later.
REQ-014 Decode SHALL be: R 0110011 {RegWrite,ALUctrl={f7[5],f3}}; load 0000011 {RegWrite,ALUsrc,CacheEn,ResultSrc=01}; I-arith 0010011 {RegWrite,ALUsrc,ALUctrl=f3==101?{f7[5],f3}:{0,f3}}; jalr 1100111 {Branch,JALR,RegWrite,ALUsrc,ResultSrc=10}; store 0100011 {MemWrite,ALUsrc,CacheEn,ImmSrc=001}; branch 1100011 {Branch,ImmSrc=010}; lui 0110111 {RegWrite,ALUsrc,ImmSrc=100,ALUctrl=1001}; jal 1101111 {Branch,JAL,RegWrite,ALUsrc,ResultSrc=10,ImmSrc=011}; auipc 0010111 {RegWrite,ALUsrc,ImmSrc=100,ResultSrc=11}; unlisted fields 0.
REQ-015 Branch ALUctrl SHALL be beq/bne 1000, blt 0011, bge 0010, bltu/bgeu 0011, other 0000.
REQ-016 DataWidth SHALL be: b 010, h 001, w 000, bu 110, hu 101; stores b/h/w only; all else 000.
REQ-017 Any other opcode (or auipc with ENABLE_AUIPC=0) SHALL set illegal=1, RegWrite/MemWrite/Branch/CacheEn=0, and increment illegal_cnt_o, saturating at all-ones.
REQ-018 FSM states RUN, BUBBLE; reset state RUN.
REQ-019 RUN->BUBBLE when the registered bundle is a load with rd!=0 and the presented instr_i reads that rd (rs1 or rs2; rs2 only for R/store/branch).
REQ-020 In BUBBLE: instr_ready_o=0, ctrl_valid_o=0 for exactly one cycle, then BUBBLE->RUN.
REQ-021 instr_ready_o SHALL be (state==RUN) && !hazard && (!ctrl_valid_o || ctrl_ready_i).
REQ-022 If ctrl_valid_o && !ctrl_ready_i, the bundle SHALL hold stable; no new accept.
REQ-023 flush_i SHALL clear ctrl_valid_o next cycle, force RUN, drop the presented instruction and block hazard detection; flush overrides a simultaneous accept, hold or bubble.
REQ-024 Instructions decoded while flush_i=1 SHALL NOT increment illegal_cnt_o.

Reset
REQ-025 While rst_n=0: state RUN, ctrl_valid_o 0, every bundle output 0, illegal_cnt_o 0; instr_ready_o follows REQ-021.
REQ-026 Reset asserted mid-bubble or mid-hold SHALL discard the pending instruction; no output glitch to valid.

Structure
REQ-027 Opcode constants, DataWidth codes, ALUctrl codes and a packed ctrl_t bundle typedef SHALL live in shared package cu_pkg.
REQ-028 Combinational decode SHALL be one sub-module cu_decode (instr in, ctrl_t out); cu_pipe holds register, FSM, hazard logic and counter.

Verification
REQ-029 Reset then 0x00A00093 (addi x1,x0,10) valid, ctrl_ready_i=1 -> next cycle ctrl_valid_o=1, RegWrite=1, ALUsrc=1, ALUctrl=0000, rd=1.
REQ-030 0x00012283 (lw x5,0(x2)) then 0x00128333 (add x6,x5,x1) -> exactly one bubble cycle, then add emitted; ResultSrc=01 for lw, 00 for add.
REQ-031 lw then add with flush_i=1 in the add's presentation cycle -> no bubble, ctrl_valid_o=0 next cycle, state RUN.
REQ-032 ctrl_ready_i=0 for 3 cycles with bundle valid -> bundle stable, instr_ready_o=0 throughout, resumes on ready.
REQ-033 CNT_W=2, five 0xFFFFFFFF instructions -> illegal=1 each, illegal_cnt_o saturates at 3.
REQ-034 ENABLE_AUIPC=0, 0x00000097 -> illegal=1; ENABLE_AUIPC=1 -> ResultSrc=11, ImmSrc=100, rd=1.
